// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial bit-pattern transmitter.
// Shifts a captured WIDTH-bit pattern out MSB-first, one bit per clock, repeating
// it a captured number of times with an optional idle gap between repetitions.
// Every pattern bit carries dout_valid; the MSB of each repetition carries frame.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | waiting for start; outputs low (done may be high for one cycle)
// S_SHIFT | a pattern bit is on dout; bit_q is the index currently shown
// S_GAP   | idle cycles between repetitions; busy stays high
module seq_pattern_gen #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] DEF_PAT = WIDTH'(4'b1011),
  parameter int               GAP     = 0,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             use_default,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic             halt,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  localparam int               BW       = $clog2(WIDTH);
  localparam logic [BW-1:0]    MSB_IDX  = BW'(WIDTH - 1);
  localparam int               GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0]    GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [CNT_W-1:0] ONE_REP  = CNT_W'(1);

  state_t           state_q;
  logic [WIDTH-1:0] pat_q;
  logic [BW-1:0]    bit_q;
  logic [CNT_W-1:0] rep_q;
  logic [GW-1:0]    gap_q;
  logic             dout_q, valid_q, frame_q, busy_q, done_q;

  logic [WIDTH-1:0] load_pat_d;
  logic [CNT_W-1:0] load_rep_d;

  // Pattern and repeat count as they would be captured by a start this cycle;
  // a repeat count of zero still sends one repetition.
  always_comb begin
    load_pat_d = use_default ? DEF_PAT : pattern_in;
    load_rep_d = (repeat_n == '0) ? ONE_REP : repeat_n;
  end

  // Sequencer: state, counters and all outputs are registered together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      bit_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          dout_q  <= 1'b0;
          valid_q <= 1'b0;
          frame_q <= 1'b0;
          busy_q  <= 1'b0;
          if (start && !halt) begin
            pat_q   <= load_pat_d;
            rep_q   <= load_rep_d;
            bit_q   <= MSB_IDX;
            dout_q  <= load_pat_d[WIDTH-1];
            valid_q <= 1'b1;
            frame_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (halt) begin
            // Abort: drop straight to idle without a done pulse.
            rep_q   <= '0;
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
            frame_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (bit_q != '0) begin
            bit_q   <= bit_q - 1'b1;
            dout_q  <= pat_q[bit_q - 1'b1];
            valid_q <= 1'b1;
            frame_q <= 1'b0;
            busy_q  <= 1'b1;
          end else if (rep_q > ONE_REP) begin
            rep_q <= rep_q - 1'b1;
            if (GAP == 0) begin
              // Back-to-back: next repetition's MSB with no bubble.
              bit_q   <= MSB_IDX;
              dout_q  <= pat_q[WIDTH-1];
              valid_q <= 1'b1;
              frame_q <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              gap_q   <= GAP_LAST;
              dout_q  <= 1'b0;
              valid_q <= 1'b0;
              frame_q <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= S_GAP;
            end
          end else begin
            rep_q   <= '0;
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
            frame_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end

        S_GAP: begin
          if (halt) begin
            rep_q   <= '0;
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
            frame_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (gap_q != '0) begin
            gap_q   <= gap_q - 1'b1;
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
            frame_q <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            bit_q   <= MSB_IDX;
            dout_q  <= pat_q[WIDTH-1];
            valid_q <= 1'b1;
            frame_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
          end
        end

        default: begin
          dout_q  <= 1'b0;
          valid_q <= 1'b0;
          frame_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign frame      = frame_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: one instance with GAP=0 and one with GAP=2 share
// the same stimulus. A per-instance queue holds the expected output word
// {dout, dout_valid, frame, busy, done} for every upcoming cycle.
module tb_seq_pattern_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       use_default = 1'b0;
  logic       halt = 1'b0;
  logic [3:0] pattern_in = 4'h0;
  logic [7:0] repeat_n = 8'd0;

  logic dout0, v0, f0, b0, d0;
  logic dout2, v2, f2, b2, d2;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [4:0] q0[$];
  logic [4:0] q1[$];
  logic       cur_busy0 = 1'b0;
  logic       cur_busy1 = 1'b0;
  logic [4:0] e0, e1;

  seq_pattern_gen #(.WIDTH(4), .DEF_PAT(4'b1011), .GAP(0), .CNT_W(8)) u0 (
    .clk(clk), .reset(reset), .start(start), .use_default(use_default),
    .pattern_in(pattern_in), .repeat_n(repeat_n), .halt(halt),
    .dout(dout0), .dout_valid(v0), .frame(f0), .busy(b0), .done(d0)
  );

  seq_pattern_gen #(.WIDTH(4), .DEF_PAT(4'b1011), .GAP(2), .CNT_W(8)) u2 (
    .clk(clk), .reset(reset), .start(start), .use_default(use_default),
    .pattern_in(pattern_in), .repeat_n(repeat_n), .halt(halt),
    .dout(dout2), .dout_valid(v2), .frame(f2), .busy(b2), .done(d2)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] obs(input int i);
    return (i == 0) ? {dout0, v0, f0, b0, d0} : {dout2, v2, f2, b2, d2};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_e(input int i, input logic [4:0] e);
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic clear_q(input int i);
    if (i == 0) q0.delete();
    else q1.delete();
  endtask

  task automatic model_step(input int i, input logic busy_now);
    logic [3:0] p;
    int r, g;
    if (reset) clear_q(i);
    else if (busy_now && halt) clear_q(i);
    else if (!busy_now && start && !halt) begin
      p = use_default ? 4'b1011 : pattern_in;
      r = (repeat_n == 8'd0) ? 1 : int'(repeat_n);
      g = (i == 0) ? 0 : 2;
      for (int k = 0; k < r; k++) begin
        for (int b = 3; b >= 0; b--) push_e(i, {p[b], 1'b1, (b == 3), 1'b1, 1'b0});
        if (k < r - 1) for (int j = 0; j < g; j++) push_e(i, 5'b00010);
      end
      push_e(i, 5'b00001);
    end
  endtask

  // Expectation builder: sees the same inputs the DUTs sample on this edge.
  always @(posedge clk) begin
    model_step(0, cur_busy0);
    model_step(1, cur_busy1);
  end

  // Scoreboard compare, mid-cycle, against the word expected for this cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      e0 = (q0.size() != 0) ? q0.pop_front() : 5'b00000;
      e1 = (q1.size() != 0) ? q1.pop_front() : 5'b00000;
      check("sb_gap0", int'(obs(0)), int'(e0));
      check("sb_gap2", int'(obs(1)), int'(e1));
      cur_busy0 = e0[1];
      cur_busy1 = e1[1];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_measure(input logic ud, input logic [3:0] pat, input logic [7:0] rep,
                             output int d0c, output int d2c, output int busy2n,
                             output logic [15:0] bits0, output int fr0);
    d0c = 0; d2c = 0; busy2n = 0; bits0 = '0; fr0 = 0;
    start = 1'b1; use_default = ud; pattern_in = pat; repeat_n = rep;
    tick();
    start = 1'b0; use_default = ~ud; pattern_in = ~pat; repeat_n = 8'd9;
    for (int c = 1; c <= 40; c++) begin
      if (v0) bits0 = {bits0[14:0], dout0};
      if (f0) fr0++;
      if (b2) busy2n++;
      if (d0 && d0c == 0) d0c = c;
      if (d2 && d2c == 0) d2c = c;
      if (d0c != 0 && d2c != 0) break;
      start = (c == 1);
      tick();
    end
    start = 1'b0;
  endtask

  typedef struct packed {
    logic       rst, st, ud, hl;
    logic [3:0] pat;
    logic [7:0] rep;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[17];

  initial begin
    int d0c, d2c, busy2n, fr0;
    logic [15:0] bits0;
    logic saw;

    //          rst   st    ud    hl    pat      rep    {dout,valid,frame,busy,done}
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0,    8'd0, 5'b00000};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0,    8'd1, 5'b11110};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    8'd0, 5'b01010};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    8'd0, 5'b11010};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    8'd0, 5'b11010};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    8'd0, 5'b00001};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0,    8'd0, 5'b11110};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0,    8'd5, 5'b01010};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0,    8'd5, 5'b11010};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    8'd0, 5'b11010};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    8'd0, 5'b00001};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    8'd0, 5'b00000};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'h0,    8'd1, 5'b00000};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    8'd0, 5'b00000};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b1001, 8'd1, 5'b11110};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0,    8'd0, 5'b00000};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    8'd0, 5'b00000};

    reset = 1'b1;
    tick();
    mon_en = 1'b1;

    for (int r = 0; r < 17; r++) begin
      reset = tbl[r].rst; start = tbl[r].st; use_default = tbl[r].ud;
      halt = tbl[r].hl; pattern_in = tbl[r].pat; repeat_n = tbl[r].rep;
      tick();
      check($sformatf("vec%0d_gap0", r), int'(obs(0)), int'(tbl[r].exp));
      check($sformatf("vec%0d_gap2", r), int'(obs(1)), int'(tbl[r].exp));
    end
    reset = 1'b0; start = 1'b0; halt = 1'b0;
    tick();

    // Three repetitions of pattern_in, inputs scrambled while busy.
    run_measure(1'b0, 4'b0110, 8'd3, d0c, d2c, busy2n, bits0, fr0);
    check("rep3_done_gap0", d0c, 13);
    check("rep3_done_gap2", d2c, 17);
    check("rep3_bits", int'(bits0[11:0]), int'(12'b011001100110));
    check("rep3_frames", fr0, 3);
    check("rep3_busy_gap2", busy2n, 16);
    tick();

    // Default pattern twice: gap instance idles two cycles between copies.
    run_measure(1'b1, 4'b0000, 8'd2, d0c, d2c, busy2n, bits0, fr0);
    check("rep2_done_gap0", d0c, 9);
    check("rep2_done_gap2", d2c, 11);
    check("rep2_bits", int'(bits0[7:0]), int'(8'b10111011));
    check("rep2_busy_gap2", busy2n, 10);
    tick();

    // Zero repeat count sends one copy.
    run_measure(1'b1, 4'b0000, 8'd0, d0c, d2c, busy2n, bits0, fr0);
    check("rep0_done_gap0", d0c, 5);
    check("rep0_done_gap2", d2c, 5);
    check("rep0_bits", int'(bits0[3:0]), int'(4'b1011));
    tick();

    // Halt on the MSB of repetition 2 (gap instance is mid-gap then).
    start = 1'b1; use_default = 1'b1; repeat_n = 8'd3;
    tick();
    start = 1'b0;
    repeat (4) tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("halt_gap0", int'(obs(0)), 0);
    check("halt_gap2", int'(obs(1)), 0);
    saw = 1'b0;
    repeat (6) begin
      if (d0 || d2) saw = 1'b1;
      tick();
    end
    check("halt_no_done", int'(saw), 0);
    start = 1'b1; use_default = 1'b0; pattern_in = 4'b1100; repeat_n = 8'd1;
    tick();
    start = 1'b0;
    check("fresh_msb", int'({dout0, v0, f0, b0}), int'(4'b1111));
    repeat (6) tick();

    // Halt coincident with the last bit: no done pulse.
    start = 1'b1; use_default = 1'b1; repeat_n = 8'd1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("halt_last_done", int'({d0, d2}), 0);
    check("halt_last_busy", int'({b0, b2}), 0);
    repeat (3) tick();

    // Reset mid-SHIFT (gap0 instance) and mid-GAP (gap2 instance).
    start = 1'b1; use_default = 1'b1; repeat_n = 8'd2;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("pre_reset_busy", int'({b0, b2, v2}), int'(3'b110));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_gap0", int'(obs(0)), 0);
    check("reset_gap2", int'(obs(1)), 0);
    repeat (2) tick();
    check("post_reset_idle", int'({obs(0), obs(1)}), 0);

    for (int k = 0; k < 60; k++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      tick();
    end
    check("drain", q0.size() + q1.size(), 0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
